// File: rtl/systolic_input_feeder.sv
// Input feeder for the systolic skew bank: buffers operand vectors in a small FIFO,
// streams a tile of NUM_ROWS vectors, then drives SA_LENGTH-1 zero vectors to drain the array.
module systolic_input_feeder #(
    parameter int DATA_WIDTH    = 8,
    parameter int SA_LENGTH     = 256,
    parameter int FIFO_DEPTH    = 4,
    parameter int ROW_CNT_WIDTH = 16
) (
    input  logic                         CLK,
    input  logic                         SYNC_RST_N,
    input  logic                         START,
    input  logic [ROW_CNT_WIDTH-1:0]     NUM_ROWS,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic signed [DATA_WIDTH-1:0] IN_DATA [SA_LENGTH],
    output logic                         OUT_EN,
    output logic signed [DATA_WIDTH-1:0] OUT_DATA [SA_LENGTH],
    output logic                         BUSY,
    output logic                         DONE,
    output logic [1:0]                   DEBUG_STATE
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = $clog2(SA_LENGTH) + 1;
    localparam logic [FW-1:0] FLUSH_LEN = FW'(SA_LENGTH - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;

    logic [1:0]               state;
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [CW-1:0]            count;
    logic [ROW_CNT_WIDTH-1:0] rows_q;
    logic [ROW_CNT_WIDTH-1:0] acc_cnt;
    logic [ROW_CNT_WIDTH-1:0] emit_cnt;
    logic [FW-1:0]            flush_cnt;
    logic                     push;
    logic                     pop;
    logic                     fifo_full;

    logic signed [DATA_WIDTH-1:0] mem [FIFO_DEPTH][SA_LENGTH];

    // Handshake: a vector transfers at a rising edge where IN_VALID and IN_READY are both
    // high; IN_READY depends only on registered state, never on IN_VALID.
    assign fifo_full   = (count == DEPTH_C);
    assign IN_READY    = (state == S_STREAM) && !fifo_full && (acc_cnt < rows_q);
    assign push        = IN_VALID && IN_READY;
    assign pop         = (state == S_STREAM) && (count != '0) && (emit_cnt < rows_q);
    assign BUSY        = (state != S_IDLE);
    assign DEBUG_STATE = state;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= IN_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (!SYNC_RST_N) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rows_q    <= '0;
            acc_cnt   <= '0;
            emit_cnt  <= '0;
            flush_cnt <= '0;
            OUT_EN    <= 1'b0;
            DONE      <= 1'b0;
            OUT_DATA  <= '{default: '0};
        end else begin
            DONE   <= 1'b0;
            OUT_EN <= 1'b0;
            count  <= count + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                acc_cnt <= acc_cnt + 1'b1;
            end
            // An empty FIFO leaves OUT_DATA untouched so the skew bank sees a clean freeze.
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                emit_cnt <= emit_cnt + 1'b1;
                OUT_EN   <= 1'b1;
                OUT_DATA <= mem[rd_ptr];
            end
            case (state)
                S_IDLE: begin
                    if (START) begin
                        if (NUM_ROWS == '0) begin
                            DONE <= 1'b1;
                        end else begin
                            rows_q   <= NUM_ROWS;
                            acc_cnt  <= '0;
                            emit_cnt <= '0;
                            state    <= S_STREAM;
                        end
                    end
                end
                S_STREAM: begin
                    if (pop && (emit_cnt == rows_q - 1'b1)) begin
                        flush_cnt <= '0;
                        state     <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt < FLUSH_LEN) begin
                        OUT_EN    <= 1'b1;
                        OUT_DATA  <= '{default: '0};
                        flush_cnt <= flush_cnt + 1'b1;
                    end else begin
                        DONE  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Bench for systolic_input_feeder: directed tiles plus random tiles, checked every cycle
// against a queue-based model of the beat stream, handshake and DONE timing.
module tb_systolic_input_feeder;

    localparam int W     = 8;
    localparam int SA    = 4;
    localparam int DEPTH = 4;
    localparam int RW    = 16;
    localparam int VW    = W * SA;

    typedef logic [VW-1:0] vec_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [RW-1:0]       num_rows = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] in_data [SA];
    logic                out_en;
    logic signed [W-1:0] out_data [SA];
    logic                busy;
    logic                done;
    logic [1:0]          debug_state;

    always #5 clk = ~clk;

    systolic_input_feeder #(
        .DATA_WIDTH(W), .SA_LENGTH(SA), .FIFO_DEPTH(DEPTH), .ROW_CNT_WIDTH(RW)
    ) dut (
        .CLK(clk), .SYNC_RST_N(rst_n), .START(start), .NUM_ROWS(num_rows),
        .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
        .OUT_EN(out_en), .OUT_DATA(out_data), .BUSY(busy), .DONE(done),
        .DEBUG_STATE(debug_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input vec_t got, input vec_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic vec_t pack_out();
        vec_t v;
        for (int i = 0; i < SA; i++) v[i*W +: W] = out_data[i];
        return v;
    endfunction

    function automatic vec_t pack_in();
        vec_t v;
        for (int i = 0; i < SA; i++) v[i*W +: W] = in_data[i];
        return v;
    endfunction

    // Reference model: phase 0 idle, 1 data, 2 flush; exp_q holds every beat still owed.
    int   phase = 0;
    int   rows = 0;
    int   acc = 0;
    int   acc_lag = 0;
    int   emit = 0;
    int   flush_left = 0;
    bit   done_due = 1'b0;
    vec_t last_vec = '0;
    vec_t exp_q[$];

    always @(negedge clk) begin : monitor
        vec_t ov;
        logic exp_en;
        logic exp_rdy;
        int   lag;
        int   phase_now;
        if (!rst_n) begin
            phase = 0; exp_q.delete(); done_due = 1'b0; last_vec = '0;
            acc = 0; acc_lag = 0; emit = 0; flush_left = 0;
        end else begin
            ov = pack_out();
            phase_now = phase;
            lag = acc_lag;
            acc_lag = acc;
            case (phase_now)
                1:       exp_en = (emit < rows) && (lag > emit);
                2:       exp_en = (flush_left > 0);
                default: exp_en = 1'b0;
            endcase
            check("out_en", vec_t'(out_en), vec_t'(exp_en));
            check("done", vec_t'(done), vec_t'(done_due));
            check("busy", vec_t'(busy), vec_t'(phase_now != 0));
            done_due = 1'b0;
            if (out_en && exp_en && exp_q.size() > 0) check("out_data", ov, exp_q.pop_front());
            if (!out_en) check("hold_data", ov, last_vec);
            if (out_en) last_vec = ov;
            if (exp_en) begin
                if (phase_now == 1) begin
                    emit++;
                    if (emit == rows) begin
                        if (SA > 1) begin
                            phase = 2; flush_left = SA - 1;
                        end else begin
                            phase = 0; done_due = 1'b1;
                        end
                    end
                end else begin
                    flush_left--;
                    if (flush_left == 0) begin
                        phase = 0; done_due = 1'b1;
                    end
                end
            end
            exp_rdy = (phase_now == 1) && (emit < rows) && (acc < rows) && ((acc - emit) < DEPTH);
            check("in_ready", vec_t'(in_ready), vec_t'(exp_rdy));
            if (in_valid && in_ready && phase_now == 1) begin
                exp_q.push_back(pack_in());
                acc++;
                if (acc == rows) for (int i = 0; i < SA - 1; i++) exp_q.push_back('0);
            end
            if (phase_now == 0 && start) begin
                if (num_rows == '0) done_due = 1'b1;
                else begin
                    phase = 1; rows = int'(num_rows); acc = 0; acc_lag = 0; emit = 0;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_tile(input int r);
        start = 1'b1;
        num_rows = RW'(r);
        step(1);
        start = 1'b0;
    endtask

    task automatic set_vec(input vec_t v);
        for (int i = 0; i < SA; i++) in_data[i] = v[i*W +: W];
    endtask

    task automatic send_vec(input vec_t v);
        int n;
        bit took;
        n = 0;
        took = 1'b0;
        in_valid = 1'b1;
        set_vec(v);
        while (!took && n < 40) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!took) check("accept_timeout", vec_t'(took), vec_t'(1));
    endtask

    task automatic wait_tile();
        int n;
        n = 0;
        while ((phase != 0 || done_due) && n < 200) begin
            step(1);
            n++;
        end
        step(2);
        check("tile_end_busy", vec_t'(busy), vec_t'(0));
    endtask

    function automatic vec_t mk(input int a, input int b, input int c, input int d);
        vec_t v;
        v[0*W +: W] = W'(a);
        v[1*W +: W] = W'(b);
        v[2*W +: W] = W'(c);
        v[3*W +: W] = W'(d);
        return v;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        vec_t rv;
        set_vec('0);
        step(2);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_out_data", pack_out(), '0);
        check("reset_out_en", vec_t'(out_en), vec_t'(0));
        step(1);

        // zero-row tile: DONE only
        start_tile(0);
        step(3);

        // back-to-back stream
        start_tile(3);
        send_vec(mk(1, 2, 3, 4));
        send_vec(mk(-1, -2, -3, -4));
        send_vec(mk(127, -128, 0, 5));
        in_valid = 1'b0;
        wait_tile();

        // bubbles between beats
        start_tile(2);
        send_vec(mk(9, -9, 17, -17));
        in_valid = 1'b0;
        step(3);
        send_vec(mk(-100, 100, 1, -1));
        in_valid = 1'b0;
        wait_tile();

        // valid held high past the tile length
        start_tile(8);
        for (int i = 0; i < 8; i++) send_vec(vec_t'($urandom()));
        set_vec(vec_t'($urandom()));
        step(5);
        in_valid = 1'b0;
        wait_tile();

        // reset during flush, then a fresh one-row tile
        start_tile(2);
        send_vec(mk(5, 6, 7, 8));
        send_vec(mk(-5, -6, -7, -8));
        in_valid = 1'b0;
        step(3);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(3);
        start_tile(1);
        send_vec(mk(42, -42, 0, 1));
        in_valid = 1'b0;
        wait_tile();

        // START while busy is ignored
        start_tile(3);
        send_vec(mk(11, 22, 33, 44));
        start = 1'b1;
        num_rows = RW'(5);
        send_vec(mk(-11, -22, -33, -44));
        start = 1'b0;
        send_vec(mk(1, -1, 1, -1));
        in_valid = 1'b0;
        wait_tile();

        // random tiles with random gaps
        for (int t = 0; t < 6; t++) begin
            start_tile($urandom_range(1, 6));
            for (int i = 0; i < int'(num_rows); i++) begin
                rv = vec_t'($urandom());
                send_vec(rv);
                if ($urandom_range(0, 1) == 1) begin
                    in_valid = 1'b0;
                    step($urandom_range(1, 3));
                end
            end
            in_valid = 1'b0;
            wait_tile();
        end

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
